// File: rtl/dpram_pkg.sv
// dpram_pkg: shared constants and request record for the dual-port RAM controller.
package dpram_pkg;

    localparam int DPRAM_N    = 6;
    localparam int DPRAM_M    = 8;
    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic               we;
        logic [DPRAM_N-1:0] addr;
        logic [DPRAM_M-1:0] wdata;
    } dpram_req_t;

endpackage

// File: rtl/dpram_ctrl_rsp_fifo.sv
// dpram_ctrl_rsp_fifo: per-port read tracker and 2-entry response buffer.
// Occupancy counts the read in flight at the RAM plus the buffered words.
module dpram_ctrl_rsp_fifo
    import dpram_pkg::*;
#(
    parameter int M = DPRAM_M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rd_acc,
    input  logic [M-1:0] ram_data,
    input  logic         rsp_ready,
    output logic         rsp_valid,
    output logic [M-1:0] rsp_data,
    output logic         rd_ok
);

    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    logic         inflight_q, inflight_d;
    logic         wp_q, wp_d;
    logic         rp_q, rp_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [M-1:0] buf_q [FIFO_DEPTH];
    logic [M-1:0] buf_d [FIFO_DEPTH];
    logic         push, pop;
    logic [1:0]   occ;

    always_comb begin
        rsp_valid  = cnt_q != 2'd0;
        rsp_data   = buf_q[rp_q];
        push       = inflight_q;
        pop        = rsp_valid && rsp_ready;
        occ        = cnt_q + {1'b0, inflight_q};
        rd_ok      = (occ < DEPTH) || (occ == DEPTH && pop);
        inflight_d = rd_acc;
        buf_d      = buf_q;
        // RAM output is registered, so the word lands one edge after the accept
        if (push)
            buf_d[wp_q] = ram_data;
        wp_d  = wp_q ^ push;
        rp_d  = rp_q ^ pop;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            cnt_q      <= 2'd0;
            buf_q      <= '{default: '0};
        end else begin
            inflight_q <= inflight_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: rtl/dpram_ctrl.sv
// dpram_ctrl: two-client request controller for a dual-port synchronous RAM.
// Optional conflict statistics counter enabled by DPRAM_CTRL_STATS_EN.
module dpram_ctrl
    import dpram_pkg::*;
#(
    parameter int N = DPRAM_N,
    parameter int M = DPRAM_M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid_a,
    output logic         req_ready_a,
    input  logic         req_we_a,
    input  logic [N-1:0] req_addr_a,
    input  logic [M-1:0] req_wdata_a,
    output logic         rsp_valid_a,
    input  logic         rsp_ready_a,
    output logic [M-1:0] rsp_data_a,
    output logic [N-1:0] addr_a,
    output logic [M-1:0] data_in_a,
    output logic         wr_a,
    input  logic [M-1:0] data_out_a,
    input  logic         req_valid_b,
    output logic         req_ready_b,
    input  logic         req_we_b,
    input  logic [N-1:0] req_addr_b,
    input  logic [M-1:0] req_wdata_b,
    output logic         rsp_valid_b,
    input  logic         rsp_ready_b,
    output logic [M-1:0] rsp_data_b,
    output logic [N-1:0] addr_b,
    output logic [M-1:0] data_in_b,
    output logic         wr_b,
    input  logic [M-1:0] data_out_b,
    output logic [15:0]  conflict_cnt
);

    logic         conflict;
    logic         acc_a, acc_b;
    logic         rd_ok_a, rd_ok_b;
    logic [N-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [M-1:0] din_a_q, din_a_d, din_b_q, din_b_d;

    always_comb begin
        // Port A wins any same-address pairing that involves a write
        conflict    = req_valid_a && req_valid_b && (req_addr_a == req_addr_b)
                      && (req_we_a || req_we_b);
        req_ready_a = rst_n && (req_we_a || rd_ok_a);
        req_ready_b = rst_n && !conflict && (req_we_b || rd_ok_b);
        acc_a       = req_valid_a && req_ready_a;
        acc_b       = req_valid_b && req_ready_b;
        wr_a        = acc_a && req_we_a;
        wr_b        = acc_b && req_we_b;
        addr_a_d    = acc_a ? req_addr_a  : addr_a_q;
        din_a_d     = acc_a ? req_wdata_a : din_a_q;
        addr_b_d    = acc_b ? req_addr_b  : addr_b_q;
        din_b_d     = acc_b ? req_wdata_b : din_b_q;
    end

    assign addr_a    = addr_a_d;
    assign data_in_a = din_a_d;
    assign addr_b    = addr_b_d;
    assign data_in_b = din_b_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_a_q <= '0;
            din_a_q  <= '0;
            addr_b_q <= '0;
            din_b_q  <= '0;
        end else begin
            addr_a_q <= addr_a_d;
            din_a_q  <= din_a_d;
            addr_b_q <= addr_b_d;
            din_b_q  <= din_b_d;
        end
    end

    dpram_ctrl_rsp_fifo #(.M(M)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_acc    (acc_a && !req_we_a),
        .ram_data  (data_out_a),
        .rsp_ready (rsp_ready_a),
        .rsp_valid (rsp_valid_a),
        .rsp_data  (rsp_data_a),
        .rd_ok     (rd_ok_a)
    );

    dpram_ctrl_rsp_fifo #(.M(M)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_acc    (acc_b && !req_we_b),
        .ram_data  (data_out_b),
        .rsp_ready (rsp_ready_b),
        .rsp_valid (rsp_valid_b),
        .rsp_data  (rsp_data_b),
        .rd_ok     (rd_ok_b)
    );

`ifdef DPRAM_CTRL_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb
        cnt_d = (conflict && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 16'd0;
        else
            cnt_q <= cnt_d;
    end

    assign conflict_cnt = cnt_q;
`else
    assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dpram_ctrl.sv
// tb_dpram_ctrl: vector-table bench for dpram_ctrl with a behavioural dual-port RAM.
// Expected conflict counts depend on DPRAM_CTRL_STATS_EN.
module tb_dpram_ctrl;

`ifdef DPRAM_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid_a = 0, req_we_a = 0, rsp_ready_a = 1;
    logic       req_valid_b = 0, req_we_b = 0, rsp_ready_b = 1;
    logic [5:0] req_addr_a = 0, req_addr_b = 0;
    logic [7:0] req_wdata_a = 0, req_wdata_b = 0;
    logic       req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b, wr_a, wr_b;
    logic [7:0] rsp_data_a, rsp_data_b, data_in_a, data_in_b, data_out_a, data_out_b;
    logic [5:0] addr_a, addr_b;
    logic [15:0] conflict_cnt;
    logic [7:0] mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dpram_ctrl #(.N(6), .M(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .req_we_a(req_we_a),
        .req_addr_a(req_addr_a), .req_wdata_a(req_wdata_a),
        .rsp_valid_a(rsp_valid_a), .rsp_ready_a(rsp_ready_a), .rsp_data_a(rsp_data_a),
        .addr_a(addr_a), .data_in_a(data_in_a), .wr_a(wr_a), .data_out_a(data_out_a),
        .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .req_we_b(req_we_b),
        .req_addr_b(req_addr_b), .req_wdata_b(req_wdata_b),
        .rsp_valid_b(rsp_valid_b), .rsp_ready_b(rsp_ready_b), .rsp_data_b(rsp_data_b),
        .addr_b(addr_b), .data_in_b(data_in_b), .wr_b(wr_b), .data_out_b(data_out_b),
        .conflict_cnt(conflict_cnt)
    );

    always @(posedge clk) begin
        if (wr_a) mem[addr_a] <= data_in_a;
        if (wr_b) mem[addr_b] <= data_in_b;
        data_out_a <= mem[addr_a];
        data_out_b <= mem[addr_b];
    end

    typedef struct {
        logic       va, wa; logic [5:0] aa; logic [7:0] da; logic ra;
        logic       vb, wb; logic [5:0] ab; logic [7:0] db; logic rb;
        logic       e_ra, e_rb, e_wa, e_wb;
        logic       e_va; logic [7:0] e_da;
        logic       e_vb; logic [7:0] e_db;
        logic [15:0] e_cc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        // Preload, B back-pressure, A write/read, conflicts, read/read
        vq.push_back('{1,1,0,8'h10,1, 1,1,1,8'h11,1, 1,1,1,1, 0,0, 0,0, 0});
        vq.push_back('{1,1,2,8'h12,1, 1,1,3,8'h13,1, 1,1,1,1, 0,0, 0,0, 0});
        vq.push_back('{0,0,0,0,1, 1,0,0,0,0, 1,1,0,0, 0,0, 0,0, 0});
        vq.push_back('{0,0,0,0,1, 1,0,1,0,0, 1,1,0,0, 0,0, 0,0, 0});
        vq.push_back('{0,0,0,0,1, 1,0,2,0,0, 1,0,0,0, 0,0, 1,8'h10, 0});
        vq.push_back('{0,0,0,0,1, 1,0,2,0,0, 1,0,0,0, 0,0, 1,8'h10, 0});
        vq.push_back('{0,0,0,0,1, 1,0,2,0,1, 1,1,0,0, 0,0, 1,8'h10, 0});
        vq.push_back('{0,0,0,0,1, 1,0,3,0,1, 1,1,0,0, 0,0, 1,8'h11, 0});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 0,0, 1,8'h12, 0});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 0,0, 1,8'h13, 0});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 0,0, 0,0, 0});
        vq.push_back('{1,1,1,8'hAA,1, 0,0,0,0,1, 1,1,1,0, 0,0, 0,0, 0});
        vq.push_back('{1,0,1,0,1, 0,0,0,0,1, 1,1,0,0, 0,0, 0,0, 0});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 0,0, 0,0, 0});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 1,8'hAA, 0,0, 0});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 0,0, 0,0, 0});
        vq.push_back('{1,1,3,8'hF0,1, 1,0,3,0,1, 1,0,1,0, 0,0, 0,0, 0});
        vq.push_back('{0,0,0,0,1, 1,0,3,0,1, 1,1,0,0, 0,0, 0,0, 1});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 0,0, 0,0, 1});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 0,0, 1,8'hF0, 1});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 0,0, 0,0, 1});
        vq.push_back('{1,0,2,0,1, 1,0,2,0,1, 1,1,0,0, 0,0, 0,0, 1});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 0,0, 0,0, 1});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 1,8'h12, 1,8'h12, 1});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 0,0, 0,0, 1});
        vq.push_back('{1,0,0,0,1, 1,1,0,8'h44,1, 1,0,0,0, 0,0, 0,0, 1});
        vq.push_back('{0,0,0,0,1, 1,1,0,8'h44,1, 1,1,0,1, 0,0, 0,0, 2});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 1,8'h10, 0,0, 2});
        vq.push_back('{1,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 0,0, 0,0, 2});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 0,0, 0,0, 2});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 1,8'h44, 0,0, 2});
        vq.push_back('{0,0,0,0,1, 0,0,0,0,1, 1,1,0,0, 0,0, 0,0, 2});

        // Reset state, with requests presented so ready gating is visible
        req_valid_a = 1; req_valid_b = 1;
        @(negedge clk);
        chk("rst ready_a", req_ready_a, 0);
        chk("rst ready_b", req_ready_b, 0);
        chk("rst rsp_valid_a", rsp_valid_a, 0);
        chk("rst rsp_valid_b", rsp_valid_b, 0);
        chk("rst wr_a", wr_a, 0);
        chk("rst wr_b", wr_b, 0);
        chk("rst addr_a", addr_a, 0);
        chk("rst data_in_b", data_in_b, 0);
        chk("rst rsp_data_a", rsp_data_a, 0);
        chk("rst conflict_cnt", conflict_cnt, 0);
        req_valid_a = 0; req_valid_b = 0;
        rst_n = 1;

        foreach (vq[i]) begin
            @(negedge clk);
            req_valid_a = vq[i].va; req_we_a = vq[i].wa; req_addr_a = vq[i].aa;
            req_wdata_a = vq[i].da; rsp_ready_a = vq[i].ra;
            req_valid_b = vq[i].vb; req_we_b = vq[i].wb; req_addr_b = vq[i].ab;
            req_wdata_b = vq[i].db; rsp_ready_b = vq[i].rb;
            #1;
            chk($sformatf("v%0d req_ready_a", i), req_ready_a, vq[i].e_ra);
            chk($sformatf("v%0d req_ready_b", i), req_ready_b, vq[i].e_rb);
            chk($sformatf("v%0d wr_a", i), wr_a, vq[i].e_wa);
            chk($sformatf("v%0d wr_b", i), wr_b, vq[i].e_wb);
            chk($sformatf("v%0d rsp_valid_a", i), rsp_valid_a, vq[i].e_va);
            chk($sformatf("v%0d rsp_valid_b", i), rsp_valid_b, vq[i].e_vb);
            if (vq[i].e_va) chk($sformatf("v%0d rsp_data_a", i), rsp_data_a, vq[i].e_da);
            if (vq[i].e_vb) chk($sformatf("v%0d rsp_data_b", i), rsp_data_b, vq[i].e_db);
            chk($sformatf("v%0d conflict_cnt", i), conflict_cnt, STATS ? vq[i].e_cc : 16'd0);
        end

        // Two reads outstanding on A, then asynchronous reset mid-cycle
        @(negedge clk);
        req_valid_a = 1; req_we_a = 0; req_addr_a = 2; rsp_ready_a = 0;
        req_valid_b = 0; req_we_b = 0;
        #1 chk("mid rd1 ready_a", req_ready_a, 1);
        @(negedge clk);
        req_addr_a = 3;
        #1 chk("mid rd2 ready_a", req_ready_a, 1);
        @(negedge clk);
        req_valid_a = 0;
        #1 chk("mid rsp_valid_a", rsp_valid_a, 1);
        chk("mid rsp_data_a", rsp_data_a, 8'h12);
        #1 rst_n = 0;
        #1;
        chk("arst rsp_valid_a", rsp_valid_a, 0);
        chk("arst rsp_data_a", rsp_data_a, 0);
        chk("arst addr_a", addr_a, 0);
        req_valid_a = 1;
        #1 chk("arst ready_a", req_ready_a, 0);
        chk("arst wr_a", wr_a, 0);
        req_valid_a = 0;
        @(negedge clk);
        rst_n = 1;
        rsp_ready_a = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post-rst stale %0d", k), rsp_valid_a, 0);
        end
        req_valid_a = 1; req_we_a = 0; req_addr_a = 1;
        #1 chk("post-rst ready_a", req_ready_a, 1);
        chk("post-rst addr_a", addr_a, 1);
        @(negedge clk);
        req_valid_a = 0;
        #1 chk("post-rst addr hold", addr_a, 1);
        chk("post-rst inflight valid", rsp_valid_a, 0);
        lat = 0;
        while (!rsp_valid_a && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        chk("post-rst latency", lat, 1);
        chk("post-rst rsp_data_a", rsp_data_a, 8'hAA);

        // Sustained conflicts: counter saturates, or stays 0 without stats
        @(negedge clk);
        req_valid_a = 1; req_we_a = 1; req_addr_a = 7; req_wdata_a = 8'h77;
        req_valid_b = 1; req_we_b = 0; req_addr_b = 7;
        #1 chk("sat ready_b", req_ready_b, 0);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("sat conflict_cnt", conflict_cnt, STATS ? 16'hFFFF : 16'd0);
        req_valid_a = 0; req_valid_b = 0;
        @(negedge clk);
        chk("sat hold", conflict_cnt, STATS ? 16'hFFFF : 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_ctrl.md
# dpram_ctrl

Dual-port request controller that drives the address, write-data and write-enable inputs of the `dual_port_sync_ram` and collects its `data_out_a`/`data_out_b`. It sits between two independent client masters and the RAM. Each client gets a valid/ready request channel and a valid/ready read-response channel. The block resolves cross-port address conflicts and buffers read data so that client back-pressure never loses a word.

## Interface
Parameters:
- `N`, 6, address width (RAM depth 2**N)
- `M`, 8, data word width

Ports (x = a, b; one set per port):
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid_x`  in  1  request present
- `req_ready_x`  out  1  request accepted this cycle when high with `req_valid_x`
- `req_we_x`  in  1  1 = write, 0 = read
- `req_addr_x`  in  N  request address
- `req_wdata_x`  in  M  write data
- `rsp_valid_x`  out  1  read data available
- `rsp_ready_x`  in  1  client consumes read data
- `rsp_data_x`  out  M  read data
- `addr_x`  out  N  to RAM `addr_x`
- `data_in_x`  out  M  to RAM `data_in_x`
- `wr_x`  out  1  to RAM `wr_x`
- `data_out_x`  in  M  from RAM `data_out_x` (registered, valid the cycle after address is sampled)
- `conflict_cnt`  out  16  conflict statistics (see Configuration)

## Operation
- Accept: a request is accepted at rising edge E when `req_valid_x && req_ready_x` is sampled. In the cycle before E, `addr_x`/`data_in_x` drive combinationally from the request, and `wr_x = req_valid_x && req_ready_x && req_we_x`. Otherwise `wr_x` = 0 and `addr_x`/`data_in_x` hold their last values.
- Writes are posted and generate no response.
- Read pipeline per port:
  - A 2-entry response FIFO. Occupancy counts in-flight reads plus buffered words.
  - A read accepted at E has `data_out_x` valid after E. The word is pushed into the FIFO at E+1.
  - `rsp_valid_x` = FIFO non-empty. `rsp_data_x` = head entry. Responses return in order.
- `req_ready_x` for reads is high when occupancy < 2, or when occupancy == 2 and `rsp_valid_x && rsp_ready_x`. For writes it ignores occupancy.
- Conflict: both ports valid in the same cycle with `req_addr_a == req_addr_b` and at least one of them a write.
  - Port A has priority.
  - `req_ready_b` = 0 that cycle; B is retried next cycle.
  - A B read stalled behind an A write to the same address therefore returns the new data.
- Read/read to the same address is not a conflict; both proceed.
- `req_ready_x` is gated low while `rst_n` is low.

## Timing
- Reset values:
  - `rsp_valid_x`=0, `wr_x`=0, `addr_x`=0, `data_in_x`=0, `conflict_cnt`=0
  - FIFO pointers and occupancy = 0
  - `rsp_data_x` = 0 (don't-care while `rsp_valid_x` = 0)
- Read latency: accept at E gives `rsp_valid_x` high after edge E+1. Minimum request-to-response is 2 cycles.
- Throughput: one read per port per cycle, sustained while `rsp_ready_x` is held high.
- Back-pressure: with `rsp_ready_x` low, at most 2 reads are outstanding. A third read waits with `req_ready_x` = 0.
- `rsp_valid_x`/`rsp_data_x` remain stable until the handshake.
- Push and pop in the same cycle: occupancy is unchanged and data order is preserved.
- Reset asserted mid-operation: in-flight reads and buffered words are discarded, and all outputs return to reset values immediately (asynchronous). No response is produced for reads accepted before reset.
- Pointers wrap modulo 2.

## Configuration
- `DPRAM_CTRL_STATS_EN` defined: `conflict_cnt` increments by 1 at each edge where a conflict stall of port B occurs. It saturates at 16'hFFFF and is cleared only by reset.
- Not defined: the counter logic is absent and `conflict_cnt` is tied to 0. Functional behaviour is otherwise identical.

## Structure
- Package `dpram_pkg`:
  - default `N`/`M` constants
  - FIFO depth constant (2)
  - the request struct typedef (we, addr, wdata)
- Sub-module `dpram_ctrl_rsp_fifo`: per-port occupancy counter, in-flight flag and 2-entry response buffer. It is instantiated twice. The top level holds conflict arbitration, RAM port drive and the stats counter.

## Test plan
- A writes 8'hAA to addr 1, then A reads addr 1 with `rsp_ready_a`=1 → `rsp_valid_a` high 2 cycles after the read accept, `rsp_data_a`=8'hAA.
- A writes 8'hF0 to addr 3 while B reads addr 3 in the same cycle → B stalled 1 cycle (`req_ready_b`=0), then B returns 8'hF0; with stats enabled, `conflict_cnt`=1.
- B issues back-to-back reads of addrs 0–3 (preloaded 8'h10–8'h13) with `rsp_ready_b`=0 → `req_ready_b` drops after 2 accepts; releasing `rsp_ready_b` returns 8'h10, 8'h11, 8'h12, 8'h13 in order, with no loss.
- Both ports read addr 2 simultaneously → no stall, both return the same word, `conflict_cnt` unchanged.
- Assert `rst_n` low while 2 reads are outstanding on A → `rsp_valid_a`=0 immediately; after release, no stale response appears and a new read returns correct data.
- Force 70000 conflicts with `DPRAM_CTRL_STATS_EN` defined → `conflict_cnt`=16'hFFFF; without the macro → `conflict_cnt`=0 throughout.
